// File: rtl/pulse_sequencer_pkg.sv
// Shared definitions for the pulse sequencer: FSM state encoding and default sizes.
// The FSM state type lives here so the top module and the bench agree on one definition.
package pulse_sequencer_pkg;

  localparam int unsigned W_DEFAULT     = 34;
  localparam int unsigned DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/pulse_sequencer_fifo.sv
// Width-word FIFO for the pulse sequencer.
// Pushes are accepted only while not full; the head word is always visible on head_o.
module seq_fifo
  import pulse_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned W     = W_DEFAULT
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               head_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       ready_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW-1:0] wr_ptr_d, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ready_q;
  logic          push_ok, pop_ok;

  assign push_ok = push_i && ready_q;
  assign pop_ok  = pop_i && (level_q != '0);

  // DEPTH is a power of two, so plain pointer overflow gives the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ready_q  <= (level_d != LVL_FULL);
    end
  end

  // Storage carries no reset; clearing the pointers is what discards the contents.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign ready_o = ready_q;

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: feeds queued width words to a downstream pulse-width counter,
// one word per period of Period_L+1 enabled cycles, separated by a one-cycle EN=0 load gap.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned W     = W_DEFAULT
) (
  input  logic                   Clock,
  input  logic                   Reset_n,
  input  logic [W-1:0]           Wr_Data,
  input  logic                   Wr_Valid,
  output logic                   Wr_Ready,
  input  logic [W-1:0]           Period,
  input  logic                   Start,
  input  logic                   Stop,
  output logic [W-1:0]           Din,
  output logic                   EN,
  output logic                   Busy,
  output logic                   Underflow,
  output logic [$clog2(DEPTH):0] Level
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  seq_state_e     state_q;
  logic [W-1:0]   din_q;
  logic [W-1:0]   period_l_q;
  logic [W-1:0]   cnt_q, cnt_d;
  logic           en_q;
  logic           busy_q;
  logic           underflow_q;
  logic           stop_pend_q;

  logic [W-1:0]   fifo_head;
  logic [LW-1:0]  fifo_level;
  logic           fifo_pop;
  logic           last_count;
  logic           fifo_empty;
  logic           stop_now;

  seq_fifo #(
    .DEPTH (DEPTH),
    .W     (W)
  ) u_fifo (
    .clk_i   (Clock),
    .rst_ni  (Reset_n),
    .push_i  (Wr_Valid),
    .data_i  (Wr_Data),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .level_o (fifo_level),
    .ready_o (Wr_Ready)
  );

  assign fifo_pop   = (state_q == ST_LOAD);
  assign fifo_empty = (fifo_level == '0);
  assign last_count = (cnt_q == period_l_q);
  // A Stop arriving on the final count edge counts as pending for the end-of-period decision.
  assign stop_now   = stop_pend_q || Stop;

  always_comb begin
    cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      din_q       <= '0;
      period_l_q  <= '0;
      cnt_q       <= '0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      underflow_q <= 1'b0;
      stop_pend_q <= 1'b0;
    end else begin
      underflow_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (Start && !fifo_empty) begin
            period_l_q <= Period;
            busy_q     <= 1'b1;
            state_q    <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          din_q   <= fifo_head;
          cnt_q   <= '0;
          en_q    <= 1'b1;
          state_q <= ST_RUN;
          if (Stop) begin
            stop_pend_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (last_count) begin
            en_q <= 1'b0;
            if (stop_now || fifo_empty) begin
              underflow_q <= fifo_empty && !stop_now;
              stop_pend_q <= 1'b0;
              busy_q      <= 1'b0;
              state_q     <= ST_IDLE;
            end else begin
              state_q <= ST_LOAD;
            end
          end else begin
            cnt_q <= cnt_d;
            if (Stop) begin
              stop_pend_q <= 1'b1;
            end
          end
        end
        default: begin
          en_q        <= 1'b0;
          busy_q      <= 1'b0;
          stop_pend_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign Din       = din_q;
  assign EN        = en_q;
  assign Busy      = busy_q;
  assign Underflow = underflow_q;
  assign Level     = fifo_level;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: directed scenarios plus random traffic,
// compared every cycle against a queue-based behavioural model of the sequencing rules.
module tb_pulse_sequencer;

  localparam int DEPTH = 4;
  localparam int W     = 34;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          Clock;
  logic          Reset_n;
  logic [W-1:0]  Wr_Data;
  logic          Wr_Valid;
  logic          Wr_Ready;
  logic [W-1:0]  Period;
  logic          Start;
  logic          Stop;
  logic [W-1:0]  Din;
  logic          EN;
  logic          Busy;
  logic          Underflow;
  logic [LW-1:0] Level;

  int n_checks = 0;
  int n_errors = 0;

  pulse_sequencer #(.DEPTH(DEPTH), .W(W)) dut (
    .Clock     (Clock),
    .Reset_n   (Reset_n),
    .Wr_Data   (Wr_Data),
    .Wr_Valid  (Wr_Valid),
    .Wr_Ready  (Wr_Ready),
    .Period    (Period),
    .Start     (Start),
    .Stop      (Stop),
    .Din       (Din),
    .EN        (EN),
    .Busy      (Busy),
    .Underflow (Underflow),
    .Level     (Level)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Behavioural model: a word queue plus "which phase, how many enabled cycles remain".
  logic [W-1:0] mq [$];
  int           m_phase;   // 0 idle, 1 loading, 2 enabled
  longint       m_rem;     // enabled cycles remaining in this period, including the current one
  logic [W-1:0] m_pl;
  logic [W-1:0] m_din;
  bit           m_stop;
  bit           m_uf;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_phase = 0;
    m_rem   = 0;
    m_pl    = '0;
    m_din   = '0;
    m_stop  = 1'b0;
    m_uf    = 1'b0;
  endtask

  task automatic model_edge();
    int pre;
    bit push;
    pre  = mq.size();
    push = Wr_Valid && (pre != DEPTH);
    m_uf = 1'b0;
    case (m_phase)
      0: begin
        if (Start && pre > 0) begin
          m_pl    = Period;
          m_phase = 1;
        end
      end
      1: begin
        m_din   = mq.pop_front();
        m_stop  = m_stop || Stop;
        m_rem   = longint'(m_pl) + 1;
        m_phase = 2;
      end
      default: begin
        if (m_rem == 1) begin
          if (m_stop || Stop || pre == 0) begin
            m_uf    = (pre == 0) && !m_stop && !Stop;
            m_stop  = 1'b0;
            m_phase = 0;
          end else begin
            m_phase = 1;
          end
        end else begin
          m_rem  = m_rem - 1;
          m_stop = m_stop || Stop;
        end
      end
    endcase
    if (push) mq.push_back(Wr_Data);
  endtask

  task automatic compare_all();
    check_eq("EN",        64'(EN),        64'(m_phase == 2));
    check_eq("Busy",      64'(Busy),      64'(m_phase != 0));
    check_eq("Din",       64'(Din),       64'(m_din));
    check_eq("Underflow", 64'(Underflow), 64'(m_uf));
    check_eq("Level",     64'(Level),     64'(mq.size()));
    check_eq("Wr_Ready",  64'(Wr_Ready),  64'(mq.size() != DEPTH));
  endtask

  // One clock: model follows the edge, outputs are compared on the falling edge,
  // and the caller changes inputs afterwards.
  task automatic step();
    @(posedge Clock);
    model_edge();
    @(negedge Clock);
    compare_all();
  endtask

  task automatic push_word(input logic [W-1:0] d);
    Wr_Data  = d;
    Wr_Valid = 1'b1;
    step();
    Wr_Valid = 1'b0;
  endtask

  task automatic start_seq(input int p);
    Period = W'(p);
    Start  = 1'b1;
    step();
    Start  = 1'b0;
  endtask

  task automatic run_until_idle(input int budget);
    int n;
    n = 0;
    while (Busy && n < budget) begin
      step();
      n++;
    end
    check_eq("idle_timeout", 64'(Busy), 64'(0));
  endtask

  task automatic async_reset();
    #2;
    Reset_n = 1'b0;
    #1;
    check_eq("rst_EN",       64'(EN),       64'(0));
    check_eq("rst_Din",      64'(Din),      64'(0));
    check_eq("rst_Level",    64'(Level),    64'(0));
    check_eq("rst_Busy",     64'(Busy),     64'(0));
    check_eq("rst_Wr_Ready", 64'(Wr_Ready), 64'(1));
    model_reset();
    @(posedge Clock);
    @(negedge Clock);
    compare_all();
    Reset_n = 1'b1;
  endtask

  initial begin
    int cnt5, cnt10, ufs, en_hi;
    logic [4:0] pat;
    logic [63:0] rnd;

    Reset_n  = 1'b0;
    Wr_Data  = '0;
    Wr_Valid = 1'b0;
    Period   = '0;
    Start    = 1'b0;
    Stop     = 1'b0;
    model_reset();
    @(negedge Clock);
    @(negedge Clock);
    compare_all();
    Reset_n = 1'b1;

    // Two words, period 20: two 21-cycle enables, a gap, then underflow.
    push_word(W'(5));
    push_word(W'(10));
    start_seq(20);
    cnt5 = 0; cnt10 = 0; ufs = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      if (EN && Din == W'(5))  cnt5++;
      if (EN && Din == W'(10)) cnt10++;
      if (Underflow) ufs++;
    end
    check_eq("s1_en_din5",  64'(cnt5),  64'(21));
    check_eq("s1_en_din10", 64'(cnt10), 64'(21));
    check_eq("s1_underflow_pulses", 64'(ufs), 64'(1));
    $display("scenario two_words: en5=%0d en10=%0d uf=%0d", cnt5, cnt10, ufs);

    // Fill to DEPTH, then one more push that must be refused.
    for (int i = 1; i <= DEPTH; i++) push_word(W'(i));
    push_word(W'(99));
    check_eq("s2_full_level", 64'(Level),    64'(DEPTH));
    check_eq("s2_full_ready", 64'(Wr_Ready), 64'(0));
    start_seq(0);
    en_hi = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (EN) en_hi++;
    end
    check_eq("s2_words_run", 64'(en_hi), 64'(DEPTH));
    $display("scenario full_fifo: enabled cycles=%0d", en_hi);

    // Period 0 with three words: EN 1,0,1,0,1 after the first load.
    for (int i = 0; i < 3; i++) push_word(W'(20 + i));
    start_seq(0);
    pat = '0;
    for (int i = 4; i >= 0; i--) begin
      step();
      pat[i] = EN;
    end
    check_eq("s3_en_pattern", 64'(pat), 64'(5'b10101));
    step();
    check_eq("s3_busy_drop", 64'(Busy), 64'(0));
    $display("scenario period0: pattern=%b", pat);

    // Push on the same edge as the load pop leaves the level unchanged.
    push_word(W'(31));
    push_word(W'(32));
    start_seq(3);
    Wr_Data  = W'(33);
    Wr_Valid = 1'b1;
    step();
    Wr_Valid = 1'b0;
    check_eq("s4_push_pop_level", 64'(Level), 64'(2));
    run_until_idle(60);
    $display("scenario push_with_pop: level now %0d", Level);

    // Stop during the first of three words: period completes, no underflow, two left.
    for (int i = 0; i < 3; i++) push_word(W'(40 + i));
    start_seq(5);
    step();
    step();
    Stop = 1'b1;
    step();
    Stop = 1'b0;
    ufs = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (Underflow) ufs++;
    end
    check_eq("s5_stop_uf",    64'(ufs),   64'(0));
    check_eq("s5_stop_level", 64'(Level), 64'(2));
    check_eq("s5_stop_busy",  64'(Busy),  64'(0));
    $display("scenario stop: level=%0d busy=%0d", Level, Busy);

    // Asynchronous reset in the middle of a period, then Start with nothing queued.
    start_seq(10);
    for (int i = 0; i < 4; i++) step();
    async_reset();
    start_seq(3);
    step();
    check_eq("s6_empty_start_busy", 64'(Busy), 64'(0));
    $display("scenario reset_mid_run: busy=%0d level=%0d", Busy, Level);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rnd      = {$urandom(), $urandom()};
      Wr_Data  = rnd[W-1:0];
      Wr_Valid = ($urandom_range(0, 3) == 0);
      Start    = ($urandom_range(0, 15) == 0);
      Stop     = ($urandom_range(0, 31) == 0);
      Period   = W'($urandom_range(0, 6));
      step();
    end
    Wr_Valid = 1'b0;
    Start    = 1'b0;
    Stop     = 1'b0;
    $display("scenario random: 3000 cycles done");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
